// File: rtl/trace_pkg.sv
// Shared trace record types and default width constants for the trace collector.
// Records travel as flat vectors; the structs describe the default-parameter layout.
package trace_pkg;

  localparam int unsigned DEF_ARCH_LEN     = 32;
  localparam int unsigned DEF_NUM_WARPS    = 8;
  localparam int unsigned DEF_WARP_ID_BITS = $clog2(DEF_NUM_WARPS);
  localparam int unsigned DEF_NUM_LANES    = 16;
  localparam int unsigned DEF_REG_BITS     = 8;
  localparam int unsigned DEF_NUM_REGS     = 3;
  localparam int unsigned DEF_NUM_CHANNELS = 4;
  localparam int unsigned DEF_DEPTH        = 16;

  typedef struct packed {
    logic                                    en;
    logic [DEF_REG_BITS-1:0]                 addr;
    logic [DEF_NUM_LANES*DEF_ARCH_LEN-1:0]   data;
  } reg_wr_t;

  typedef struct packed {
    logic [DEF_ARCH_LEN-1:0]     pc;
    logic [DEF_WARP_ID_BITS-1:0] warp_id;
    logic [DEF_NUM_LANES-1:0]    tmask;
    reg_wr_t [DEF_NUM_REGS-1:0]  regs;
  } trace_rec_t;

  // Flat record width; layout MSB->LSB is {pc, warp_id, tmask, regs}.
  function automatic int unsigned rec_width(input int unsigned arch_len,
                                            input int unsigned num_warps,
                                            input int unsigned num_lanes,
                                            input int unsigned reg_bits,
                                            input int unsigned num_regs);
    return arch_len + $clog2(num_warps) + num_lanes +
           num_regs * (1 + reg_bits + num_lanes * arch_len);
  endfunction

  function automatic int unsigned ch_bits(input int unsigned num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  localparam int unsigned DEF_REC_W = rec_width(DEF_ARCH_LEN, DEF_NUM_WARPS, DEF_NUM_LANES,
                                                DEF_REG_BITS, DEF_NUM_REGS);

endpackage

// File: rtl/trace_collector_if.sv
// Trace source/consumer bundle: per-channel record strobes in, single FIFO head out.
interface trace_collector_if
  import trace_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned REC_W        = DEF_REC_W,
  parameter int unsigned CH_BITS      = ch_bits(NUM_CHANNELS)
);

  logic [NUM_CHANNELS-1:0]            in_valid;
  logic [NUM_CHANNELS-1:0][REC_W-1:0] in_record;
  logic                               out_valid;
  logic                               out_ready;
  logic [CH_BITS-1:0]                 out_channel;
  logic [REC_W-1:0]                   out_record;

  modport master (
    output in_valid,
    output in_record,
    output out_ready,
    input  out_valid,
    input  out_channel,
    input  out_record
  );

  modport slave (
    input  in_valid,
    input  in_record,
    input  out_ready,
    output out_valid,
    output out_channel,
    output out_record
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous valid/ready FIFO; pointers carry an extra wrap bit to tell full from empty.
// Accepts a push while full when the head is popped in the same cycle.
module trace_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_d, wptr_q;
  logic [AddrW:0]   rptr_d, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             full, empty, push, pop;

  always_comb begin
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                  (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    out_valid_o = !empty;
    in_ready_o  = !full || out_ready_i;
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
    wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
    // Zero head while empty so the output is clean during and after reset.
    out_data_o  = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AddrW-1:0]] <= in_data_i;
    end
  end

endmodule

// File: rtl/trace_collector.sv
// Multi-channel trace collector: per-channel hold registers, round-robin arbiter, shared FIFO.
// Define TRACE_COLLECTOR_STATS_EN to add per-channel accept_count outputs.
module trace_collector
  import trace_pkg::*;
#(
  parameter int unsigned ARCH_LEN           = DEF_ARCH_LEN,
  parameter int unsigned NUM_WARPS          = DEF_NUM_WARPS,
  parameter int unsigned NUM_LANES          = DEF_NUM_LANES,
  parameter int unsigned REG_BITS           = DEF_REG_BITS,
  parameter int unsigned NUM_REGS           = DEF_NUM_REGS,
  parameter int unsigned NUM_CHANNELS       = DEF_NUM_CHANNELS,
  parameter int unsigned DEPTH              = DEF_DEPTH,
  parameter bit          FILTER_EMPTY_TMASK = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  trace_collector_if.slave              bus,
  input  logic                          clear_counts,
  output logic [NUM_CHANNELS-1:0][31:0] drop_count
`ifdef TRACE_COLLECTOR_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][31:0] accept_count
`endif
);

  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
  localparam int unsigned CH_BITS      = ch_bits(NUM_CHANNELS);
  localparam int unsigned TMASK_LSB    = NUM_REGS * (1 + REG_BITS + NUM_LANES * ARCH_LEN);
  localparam int unsigned REC_W        = ARCH_LEN + WARP_ID_BITS + NUM_LANES + TMASK_LSB;
  localparam int unsigned FIFO_W       = CH_BITS + REC_W;
  // Last-granted resets to the top channel so channel 0 wins first.
  localparam logic [CH_BITS-1:0] LAST_RST = CH_BITS'(NUM_CHANNELS - 1);

  typedef logic [REC_W-1:0] rec_t;

  logic [NUM_CHANNELS-1:0]        hold_valid_d, hold_valid_q;
  rec_t [NUM_CHANNELS-1:0]        hold_rec_d, hold_rec_q;
  logic [CH_BITS-1:0]             last_grant_d, last_grant_q;
  logic [NUM_CHANNELS-1:0][31:0]  drop_cnt_d, drop_cnt_q;

  logic [NUM_CHANNELS-1:0]        rec_keep;
  logic [NUM_CHANNELS-1:0]        drop_evt;
  logic [NUM_CHANNELS-1:0]        grant_oh;
  logic                           grant_valid;
  logic [CH_BITS-1:0]             grant_idx;
  int unsigned                    rr_idx;

  logic                           fifo_in_ready;
  logic [FIFO_W-1:0]              fifo_in_data;
  logic [FIFO_W-1:0]              fifo_out_data;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rec_keep[c] = bus.in_valid[c];
      if (FILTER_EMPTY_TMASK && (bus.in_record[c][TMASK_LSB +: NUM_LANES] == '0)) begin
        rec_keep[c] = 1'b0;
      end
    end
  end

  // Round-robin: scan starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    rr_idx      = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rr_idx = (32'(last_grant_q) + 32'd1 + 32'(i)) % NUM_CHANNELS;
      if (fifo_in_ready && !grant_valid && hold_valid_q[rr_idx]) begin
        grant_valid      = 1'b1;
        grant_idx        = CH_BITS'(rr_idx);
        grant_oh[rr_idx] = 1'b1;
      end
    end
    last_grant_d = grant_valid ? grant_idx : last_grant_q;
    fifo_in_data = {grant_idx, hold_rec_q[grant_idx]};
  end

  always_comb begin
    hold_valid_d = hold_valid_q & ~grant_oh;
    hold_rec_d   = hold_rec_q;
    drop_evt     = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rec_keep[c]) begin
        if (hold_valid_q[c] && !grant_oh[c]) begin
          drop_evt[c] = 1'b1;
        end else begin
          hold_valid_d[c] = 1'b1;
          hold_rec_d[c]   = bus.in_record[c];
        end
      end
    end
  end

  // Clear first, then count, so a coincident drop leaves the counter at 1.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      drop_cnt_d[c] = clear_counts ? 32'd0 : drop_cnt_q[c];
      if (drop_evt[c] && (drop_cnt_d[c] != 32'hFFFF_FFFF)) begin
        drop_cnt_d[c] = drop_cnt_d[c] + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= '0;
      hold_rec_q   <= '0;
      last_grant_q <= LAST_RST;
      drop_cnt_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rec_q   <= hold_rec_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .Width (FIFO_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .in_valid_i  (grant_valid),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   (fifo_in_data),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (fifo_out_data)
  );

  assign bus.out_channel = fifo_out_data[FIFO_W-1 -: CH_BITS];
  assign bus.out_record  = fifo_out_data[REC_W-1:0];
  assign drop_count      = drop_cnt_q;

`ifdef TRACE_COLLECTOR_STATS_EN
  logic [NUM_CHANNELS-1:0][31:0] accept_cnt_d, accept_cnt_q;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      accept_cnt_d[c] = clear_counts ? 32'd0 : accept_cnt_q[c];
      if (grant_oh[c] && (accept_cnt_d[c] != 32'hFFFF_FFFF)) begin
        accept_cnt_d[c] = accept_cnt_d[c] + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accept_cnt_q <= '0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign accept_count = accept_cnt_q;
`endif

endmodule

// File: tb/tb_trace_collector.sv
// Directed bench for trace_collector: an unfiltered and a tmask-filtering instance
// share one stimulus stream; expectations are hand-derived.
module tb_trace_collector;
  import trace_pkg::*;

  localparam int unsigned REC_W = DEF_REC_W;
  localparam int unsigned NCH   = DEF_NUM_CHANNELS;
  typedef logic [REC_W-1:0] rec_t;

  logic clock;
  logic reset;
  logic clear_counts;
  logic [NCH-1:0][31:0] drop0, drop1;
`ifdef TRACE_COLLECTOR_STATS_EN
  logic [NCH-1:0][31:0] acc0, acc1;
`endif

  int checks   = 0;
  int failures = 0;

  trace_collector_if #(.NUM_CHANNELS(NCH), .REC_W(REC_W), .CH_BITS(2)) bus0 ();
  trace_collector_if #(.NUM_CHANNELS(NCH), .REC_W(REC_W), .CH_BITS(2)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_record = bus0.in_record;
  assign bus1.out_ready = bus0.out_ready;

  trace_collector #(.FILTER_EMPTY_TMASK(1'b0)) u_dut0 (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus0),
    .clear_counts (clear_counts),
    .drop_count   (drop0)
`ifdef TRACE_COLLECTOR_STATS_EN
    ,
    .accept_count (acc0)
`endif
  );

  trace_collector #(.FILTER_EMPTY_TMASK(1'b1)) u_dut1 (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus1),
    .clear_counts (clear_counts),
    .drop_count   (drop1)
`ifdef TRACE_COLLECTOR_STATS_EN
    ,
    .accept_count (acc1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk_rec(input logic [31:0] pc, input logic [2:0] warp,
                                  input logic [15:0] tmask, input logic [7:0] seed);
    trace_rec_t  r;
    logic [31:0] w;
    r.pc      = pc;
    r.warp_id = warp;
    r.tmask   = tmask;
    for (int k = 0; k < DEF_NUM_REGS; k++) begin
      w              = pc ^ {seed, 8'(k), 16'h5a5a};
      r.regs[k].en   = (k != 1);
      r.regs[k].addr = seed + 8'(k);
      r.regs[k].data = {DEF_NUM_LANES{w}};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t obs, input rec_t exp);
    trace_rec_t o, e;
    o = obs;
    e = exp;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got pc=%0h tmask=%0h r0=%0h, expected pc=%0h tmask=%0h r0=%0h",
             tag, o.pc, o.tmask, o.regs[0].data[31:0], e.pc, e.tmask, e.regs[0].data[31:0]);
    end
  endtask

  task automatic head(input string tag, input logic [1:0] ch, input rec_t rec);
    chk({tag, "_valid"}, 64'(bus0.out_valid), 64'd1);
    chk({tag, "_chan"}, 64'(bus0.out_channel), 64'(ch));
    chk_rec({tag, "_rec"}, bus0.out_record, rec);
  endtask

  rec_t rec_b [4];
  rec_t rec_c [21];
  rec_t rec_a, rec_r0, rec_r3, rec_z, rec_e;

  initial begin
    reset          = 1'b0;
    clear_counts   = 1'b0;
    bus0.in_valid  = '0;
    bus0.in_record = '0;
    bus0.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_channel", 64'(bus0.out_channel), 64'd0);
    chk_rec("rst_out_record", bus0.out_record, '0);
    chk("rst_drop", 64'(|drop0), 64'd0);
    repeat (2) step();
    reset          = 1'b1;
    bus0.out_ready = 1'b1;

    // All four channels at once: round-robin from channel 0.
    for (int c = 0; c < 4; c++) begin
      rec_b[c]          = mk_rec(32'h100 + 32'(c) * 32'h10, 3'(c), 16'h000F << (4 * c), 8'(c));
      bus0.in_record[c] = rec_b[c];
    end
    bus0.in_valid = 4'hF;
    step();
    bus0.in_valid = '0;
    chk("all_latency", 64'(bus0.out_valid), 64'd0);
    step();
    head("all_ch0", 2'd0, rec_b[0]);
    step();
    head("all_ch1", 2'd1, rec_b[1]);
    step();
    head("all_ch2", 2'd2, rec_b[2]);
    step();
    head("all_ch3", 2'd3, rec_b[3]);
    step();
    chk("all_drained", 64'(bus0.out_valid), 64'd0);
    chk("all_no_drop", 64'(|drop0), 64'd0);

    // Single record on channel 1, two-edge latency.
    rec_a             = mk_rec(32'h8000_0000, 3'd5, 16'hFFFF, 8'h11);
    bus0.in_record[1] = rec_a;
    bus0.in_valid     = 4'b0010;
    step();
    bus0.in_valid = '0;
    chk("single_early", 64'(bus0.out_valid), 64'd0);
    step();
    head("single", 2'd1, rec_a);
    step();
    chk("single_popped", 64'(bus0.out_valid), 64'd0);

    // Last grant was channel 1, so channel 3 outranks channel 0.
    rec_r0            = mk_rec(32'h400, 3'd0, 16'h0101, 8'h20);
    rec_r3            = mk_rec(32'h700, 3'd3, 16'h8080, 8'h23);
    bus0.in_record[0] = rec_r0;
    bus0.in_record[3] = rec_r3;
    bus0.in_valid     = 4'b1001;
    step();
    bus0.in_valid = '0;
    step();
    head("rot_first", 2'd3, rec_r3);
    step();
    head("rot_second", 2'd0, rec_r0);
    step();

    // Empty tmask: filtered instance ignores it, unfiltered one forwards it.
    rec_z             = mk_rec(32'h2000, 3'd1, 16'h0000, 8'h33);
    bus0.in_record[2] = rec_z;
    bus0.in_valid     = 4'b0100;
    step();
    bus0.in_valid = '0;
    step();
    chk("filt_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("filt_drop", 64'(drop1[2]), 64'd0);
    head("nofilt", 2'd2, rec_z);
    step();

    // Stall the consumer and flood channel 0 for 20 cycles.
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      rec_c[i] = mk_rec(32'h1000 + 32'(i), 3'd2, 16'h00FF, 8'(8'h40 + i));
    end
    for (int i = 0; i < 20; i++) begin
      bus0.in_record[0] = rec_c[i];
      bus0.in_valid     = 4'b0001;
      step();
    end
    bus0.in_valid = '0;
    chk("flood_drop", 64'(drop0[0]), 64'd3);
    head("flood_head", 2'd0, rec_c[0]);

    // Clear coinciding with a drop leaves the counter at 1.
    bus0.in_record[0] = rec_c[20];
    bus0.in_valid     = 4'b0001;
    clear_counts      = 1'b1;
    step();
    bus0.in_valid = '0;
    clear_counts  = 1'b0;
    chk("clr_with_drop", 64'(drop0[0]), 64'd1);

    // Pop and grant in the same cycle on a full FIFO.
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;
    head("pushpop_head", 2'd0, rec_c[1]);
    step();
    head("stall_stable", 2'd0, rec_c[1]);
    bus0.out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      head("drain", 2'd0, rec_c[k]);
      step();
    end
    chk("drain_empty", 64'(bus0.out_valid), 64'd0);
    chk("drain_drop_kept", 64'(drop0[0]), 64'd1);

    // Reset with five records buffered (four in the FIFO, one held).
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus0.in_record[3] = mk_rec(32'h3000 + 32'(i), 3'd4, 16'hF0F0, 8'(8'h60 + i));
      bus0.in_valid     = 4'b1000;
      step();
    end
    bus0.in_valid = '0;
    chk("pre_rst_valid", 64'(bus0.out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus0.out_valid), 64'd0);
    chk("mid_rst_chan", 64'(bus0.out_channel), 64'd0);
    chk_rec("mid_rst_rec", bus0.out_record, '0);
    step();
    reset = 1'b1;
    chk("post_rst_drop", 64'(drop0[0]), 64'd0);
    repeat (2) step();
    chk("post_rst_empty", 64'(bus0.out_valid), 64'd0);

    bus0.out_ready    = 1'b1;
    rec_e             = mk_rec(32'h5000, 3'd6, 16'h1234, 8'h77);
    bus0.in_record[2] = rec_e;
    bus0.in_valid     = 4'b0100;
    step();
    bus0.in_valid = '0;
    step();
    head("post_rst_rec", 2'd2, rec_e);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_collector.md
TRACE_COLLECTOR -- requirements
Module: trace_collector

Interface
REQ-001 SHALL have parameter ARCH_LEN, default 32, architectural data/PC width.
REQ-002 SHALL have parameter NUM_WARPS, default 8, warps per core; WARP_ID_BITS = $clog2(NUM_WARPS).
REQ-003 SHALL have parameter NUM_LANES, default 16, lanes per warp (tmask width).
REQ-004 SHALL have parameter REG_BITS, default 8, register address width.
REQ-005 SHALL have parameter NUM_REGS, default 3, register-write slots per record.
REQ-006 SHALL have parameter NUM_CHANNELS, default 4, independent trace sources; CH_BITS = max(1,$clog2(NUM_CHANNELS)).
REQ-007 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=2).
REQ-008 SHALL have parameter FILTER_EMPTY_TMASK, default 0, 1 = discard records with tmask==0.
REQ-009 SHALL have port clock, input, 1, sole clock; all state on its rising edge.
REQ-010 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-011 SHALL have port in_valid, input, NUM_CHANNELS, per-channel record strobe; no ready, sources never stall.
REQ-012 SHALL have port in_record, input, NUM_CHANNELS x record, per channel: pc, warpId, tmask, NUM_REGS x {enable, address, NUM_LANES*ARCH_LEN data}.
REQ-013 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-014 SHALL have port out_ready, input, 1, consumer accept.
REQ-015 SHALL have port out_channel, output, CH_BITS, source channel of head record.
REQ-016 SHALL have port out_record, output, record, head record.
REQ-017 SHALL have port drop_count, output, NUM_CHANNELS x 32, per-channel saturating drop counters.
REQ-018 SHALL have port clear_counts, input, 1, synchronous counter clear.

Function
REQ-019 Each channel SHALL own a one-entry hold register; in_valid[c] with hold empty (or being granted this cycle) SHALL capture the record at the edge.
REQ-020 in_valid[c] with hold full and not granted SHALL discard the new record and increment drop_count[c], saturating at 2^32-1.
REQ-021 With FILTER_EMPTY_TMASK=1, tmask==0 records SHALL be discarded without capture and without counting.
REQ-022 A round-robin arbiter SHALL grant one full hold register per cycle when the FIFO is not full or is being popped this cycle; priority starts after last granted channel; after reset, channel 0 highest.
REQ-023 Grant SHALL write {channel, record} into the FIFO and empty that hold register at the same edge.
REQ-024 Minimum latency: in_valid at edge N, out_valid high after edge N+2.
REQ-025 Pop SHALL occur when out_valid && out_ready; out_record/out_channel SHALL be stable while out_valid && !out_ready.
REQ-026 FIFO full SHALL block grants (holds retain data); FIFO empty SHALL hold out_valid low; pointers SHALL wrap modulo DEPTH with an extra wrap bit distinguishing full from empty.
REQ-027 Simultaneous push and pop on a full FIFO SHALL succeed with count unchanged.
REQ-028 clear_counts SHALL zero all drop_count at the edge; a coincident drop SHALL leave that counter at 1.
REQ-029 Records SHALL leave in per-channel arrival order.

Reset
REQ-030 Reset assertion SHALL immediately empty all holds and FIFO, zero pointers and drop_count, drive out_valid=0, reset arbiter priority to channel 0.
REQ-031 Reset mid-operation SHALL discard all buffered records without counting them as drops.
REQ-032 out_record/out_channel SHALL be zero during reset.

Configuration
REQ-033 Macro TRACE_COLLECTOR_STATS_EN defined SHALL add output accept_count (NUM_CHANNELS x 32), per-channel saturating count of FIFO-written records, cleared by reset and clear_counts.
REQ-034 Macro undefined SHALL omit accept_count and its logic; all other behaviour identical.

Structure
REQ-035 Package trace_pkg SHALL hold the trace record struct, per-register-write struct, and default width constants.
REQ-036 FIFO SHALL be sub-module trace_fifo (parametrised width/depth, valid/ready both sides); hold registers and arbiter stay in trace_collector.

Verification
REQ-037 Channel 1 single record pc=0x80000000, tmask=0xFFFF, out_ready=1 -> out_valid after 2 edges, out_channel=1, fields match.
REQ-038 All 4 channels valid same cycle, out_ready=1 -> output order ch0,ch1,ch2,ch3 on consecutive cycles, no drops.
REQ-039 out_ready=0, channel 0 valid 20 consecutive cycles, DEPTH=16 -> 16 queued, hold full, drop_count[0]=3.
REQ-040 FILTER_EMPTY_TMASK=1, tmask=0 record -> no out_valid, drop_count unchanged.
REQ-041 FIFO full, pop plus grant same cycle -> count stays 16, head advances.
REQ-042 Reset asserted with 5 buffered -> out_valid=0 immediately, drop_count=0 after release.
